// File: rtl/alu32_bist_if.sv
// alu32_bist_if: control/status handshake and ALU operand/result bus of the ALU32 self-test engine.
interface alu32_bist_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] alu_dataa;
    logic [31:0] alu_datab;
    logic [3:0]  alu_aluctr;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [3:0]  fail_ctr;
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic [31:0] fail_got;

    modport master (
        input  start, alu_result, alu_zero,
        output busy, done, pass, err_count, alu_dataa, alu_datab, alu_aluctr,
               fail_ctr, fail_a, fail_b, fail_got
    );

    modport slave (
        output start, alu_result, alu_zero,
        input  busy, done, pass, err_count, alu_dataa, alu_datab, alu_aluctr,
               fail_ctr, fail_a, fail_b, fail_got
    );
endinterface

// File: rtl/alu32_bist.sv
// alu32_bist: drives ALU32 through 11 ops x 3 operand sets per iteration and counts result/zero mismatches.
// Define ALU32_BIST_FAILLOG_EN to latch the first failing vector onto fail_*.
module alu32_bist #(
    parameter int          ITERATIONS = 10000,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input logic          clk,
    input logic          rst_n,
    alu32_bist_if.master bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LAST_ITER = 32'(ITERATIONS - 1);

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Op indices 0..8 coincide with their codes; only SRA and LUI sit elsewhere.
    function automatic logic [3:0] opcode(input logic [3:0] i);
        return (i == 4'd9) ? 4'b1101 : (i == 4'd10) ? 4'b1111 : i;
    endfunction

    function automatic logic [31:0] golden(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1000: return a - b;
            4'b1101: return $signed(a) >>> b[4:0];
            default: return b;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  set_q, set_d;
    logic [31:0] iter_q, iter_d;
    logic [31:0] a_q, a_d, lfsr_q, lfsr_d;
    logic [31:0] dataa_q, dataa_d, datab_q, datab_d;
    logic [3:0]  ctr_q, ctr_d;
    logic [15:0] err_q, err_d;
    logic        done_q, done_d, pass_q, pass_d;
    logic        accept, fresh, miss, last_op, last_set, last_iter;
    logic [31:0] l1, l2, expv;

    assign accept    = (state_q == IDLE || state_q == DONE) && bus.start;
    assign fresh     = set_q == 2'd2 && op_q == 4'd0;
    assign l1        = step(lfsr_q);
    assign l2        = step(l1);
    assign expv      = golden(ctr_q, dataa_q, datab_q);
    assign miss      = bus.alu_result != expv || bus.alu_zero != (expv == 32'h0);
    assign last_op   = op_q == 4'd10;
    assign last_set  = set_q == 2'd2;
    assign last_iter = iter_q == LAST_ITER;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        set_d   = set_q;
        iter_d  = iter_q;
        a_d     = a_q;
        lfsr_d  = lfsr_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        ctr_d   = ctr_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: if (accept) begin
                state_d = DRIVE;
                op_d    = '0;
                set_d   = '0;
                iter_d  = '0;
                a_d     = SEED_EFF;
                lfsr_d  = SEED_EFF;
                err_d   = '0;
            end
            DRIVE: begin
                state_d = CHECK;
                ctr_d   = opcode(op_q);
                dataa_d = fresh ? l1 : a_q;
                datab_d = fresh ? l2 : (set_q == 2'd0) ? ~a_q : (set_q == 2'd1) ? a_q : lfsr_q;
                if (fresh) begin
                    a_d    = l1;
                    lfsr_d = l2;
                end
            end
            CHECK: begin
                if (miss && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                op_d    = last_op ? 4'd0 : op_q + 4'd1;
                set_d   = !last_op ? set_q : last_set ? 2'd0 : set_q + 2'd1;
                iter_d  = (last_op && last_set) ? iter_q + 32'd1 : iter_q;
                state_d = (last_op && last_set && last_iter) ? DONE : DRIVE;
            end
        endcase
        done_d = state_q == DONE && !accept;
        pass_d = done_d && err_q == 16'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            set_q   <= '0;
            iter_q  <= '0;
            a_q     <= SEED_EFF;
            lfsr_q  <= SEED_EFF;
            dataa_q <= '0;
            datab_q <= '0;
            ctr_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            set_q   <= set_d;
            iter_q  <= iter_d;
            a_q     <= a_d;
            lfsr_q  <= lfsr_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            ctr_q   <= ctr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy       = state_q == DRIVE || state_q == CHECK;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.alu_dataa  = dataa_q;
    assign bus.alu_datab  = datab_q;
    assign bus.alu_aluctr = ctr_q;

`ifdef ALU32_BIST_FAILLOG_EN
    logic [99:0] fail_q, fail_d;

    // A zero count at the moment of a mismatch marks the first failure of the run.
    always_comb fail_d = accept ? '0
                       : (state_q == CHECK && miss && err_q == 16'h0) ? {ctr_q, dataa_q, datab_q, bus.alu_result}
                       : fail_q;

    always_ff @(posedge clk) begin
        if (!rst_n) fail_q <= '0;
        else fail_q <= fail_d;
    end

    assign {bus.fail_ctr, bus.fail_a, bus.fail_b, bus.fail_got} = fail_q;
`else
    assign {bus.fail_ctr, bus.fail_a, bus.fail_b, bus.fail_got} = '0;
`endif
endmodule

// File: tb/tb_alu32_bist.sv
// tb_alu32_bist: directed runs of alu32_bist against a faultable bench ALU and a sequence-level model.
`timescale 1ns/1ps
module tb_alu32_bist;
    localparam int N = 2;
    localparam int K = 33 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   fault = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu32_bist_if b1 ();
    alu32_bist_if b0 ();

    alu32_bist #(.ITERATIONS(N), .SEED(32'h1)) dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
    alu32_bist #(.ITERATIONS(N), .SEED(32'h0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    assign b1.start = start;
    assign b0.start = start;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a << sh;
            4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return a - b;
            4'd13: return $signed(a) >>> sh;
            4'd15: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Fault modes: 1 SUB computes ADD, 2 zero flag stuck low, 3 SRA result bit0 flipped.
    function automatic logic [32:0] bench_alu(input int f, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = (f == 1 && c == 4'd8) ? a + b : ref_alu(c, a, b);
        if (f == 3 && c == 4'd13) r = r ^ 32'h1;
        return {f != 2 && r == 32'h0, r};
    endfunction

    always_comb {b1.alu_zero, b1.alu_result} = bench_alu(fault, b1.alu_aluctr, b1.alu_dataa, b1.alu_datab);
    always_comb {b0.alu_zero, b0.alu_result} = bench_alu(fault, b0.alu_aluctr, b0.alu_dataa, b0.alu_datab);

    logic [3:0]  vc [K];
    logic [31:0] va [K];
    logic [31:0] vb [K];
    int          ncum [K];
    int          rcum [K];
    int          nfirst = -1;
    int          rfirst = -1;
    logic [31:0] ngot = 32'h0;
    logic [31:0] rgot = 32'h0;

    task automatic build_vectors();
        logic [3:0]  ops [11];
        logic [31:0] a, b, l;
        int k;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd15};
        a = 32'h1;
        l = 32'h1;
        k = 0;
        for (int it = 0; it < N; it++) begin
            for (int p = 0; p < 3; p++) begin
                if (p == 2) begin
                    a = lstep(l);
                    l = lstep(a);
                    b = l;
                end else begin
                    b = (p == 0) ? ~a : a;
                end
                for (int o = 0; o < 11; o++) begin
                    vc[k] = ops[o];
                    va[k] = a;
                    vb[k] = b;
                    k++;
                end
            end
        end
    endtask

    task automatic build_cum(input int f);
        int e;
        logic [31:0] r;
        logic [32:0] g;
        e = 0;
        nfirst = -1;
        ngot = 32'h0;
        for (int k = 0; k < K; k++) begin
            r = ref_alu(vc[k], va[k], vb[k]);
            g = bench_alu(f, vc[k], va[k], vb[k]);
            if (g != {r == 32'h0, r}) begin
                if (nfirst < 0) begin
                    nfirst = k;
                    ngot = g[31:0];
                end
                e++;
            end
            ncum[k] = (e > 65535) ? 65535 : e;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    int mt = -1;
    bit mon = 1'b0;

    always @(negedge clk) begin : cmp
        int ki, ei;
        bit fv;
        if (mon) begin
            ki = (mt < 1) ? 0 : (((mt - 1) / 2 > K - 1) ? K - 1 : (mt - 1) / 2);
            ei = (mt < 2) ? -1 : ((mt / 2 - 1 > K - 1) ? K - 1 : mt / 2 - 1);
            chk("busy", b1.busy, mt >= 0 && mt < 2 * K);
            chk("busy0", b0.busy, mt >= 0 && mt < 2 * K);
            chk("done", b1.done, mt > 2 * K);
            chk("pass", b1.pass, mt > 2 * K && rcum[K-1] == 0);
            chk("err", b1.err_count, (ei < 0) ? 0 : rcum[ei]);
            chk("err0", b0.err_count, (ei < 0) ? 0 : rcum[ei]);
            if (mt >= 1) begin
                chk("dataa", b1.alu_dataa, va[ki]);
                chk("datab", b1.alu_datab, vb[ki]);
                chk("aluctr", b1.alu_aluctr, vc[ki]);
                chk("dataa_seed0", b0.alu_dataa, va[ki]);
                chk("datab_seed0", b0.alu_datab, vb[ki]);
            end else if (mt < 0) begin
                chk("rst_dataa", b1.alu_dataa, 0);
                chk("rst_datab", b1.alu_datab, 0);
                chk("rst_aluctr", b1.alu_aluctr, 0);
            end
`ifdef ALU32_BIST_FAILLOG_EN
            fv = ei >= 0 && rfirst >= 0 && ei >= rfirst;
            chk("fail_ctr", b1.fail_ctr, fv ? vc[rfirst] : 0);
            chk("fail_a", b1.fail_a, fv ? va[rfirst] : 0);
            chk("fail_b", b1.fail_b, fv ? vb[rfirst] : 0);
            chk("fail_got", b1.fail_got, fv ? rgot : 0);
`else
            fv = 1'b0;
            chk("fail_tied", {b1.fail_ctr, 27'h0, fv}, 0);
            chk("fail_a_tied", b1.fail_a | b1.fail_b | b1.fail_got, 0);
`endif
            if (!rst_n) mt = -1;
            else if (start && (mt < 0 || mt >= 2 * K)) begin
                mt = 0;
                rcum = ncum;
                rfirst = nfirst;
                rgot = ngot;
            end else if (mt >= 0 && mt < 100000) mt++;
        end
    end

    task automatic go(input int f);
        int n;
        n = 0;
        @(posedge clk);
        #1 fault = f;
        build_cum(f);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!b1.done && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, 2 * K + 1);
    endtask

    initial begin
        build_vectors();
        build_cum(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon = 1'b1;
        repeat (3) @(posedge clk);
        chk("pin_v0_a", va[0], 32'h0000_0001);
        chk("pin_v0_b", vb[0], 32'hFFFF_FFFE);
        chk("pin_p2_a", va[22], 32'h8020_0003);
        chk("pin_p2_b", vb[22], 32'hC030_0002);
        chk("pin_it1_b", vb[33], 32'h7FDF_FFFC);
        chk("pin_ctr9", vc[9], 32'hD);
        go(0);
        chk("clean_err", b1.err_count, 0);
        chk("clean_pass", b1.pass, 1);
        go(1);
        chk("subadd_err", b1.err_count, 6);
        chk("subadd_pass", b1.pass, 0);
        go(2);
        chk("zero_ge5", b1.err_count >= 16'd5, 1);
        go(3);
`ifdef ALU32_BIST_FAILLOG_EN
        chk("sra_fail_ctr", b1.fail_ctr, 32'hD);
        chk("sra_fail_a", b1.fail_a, 32'h0000_0001);
        chk("sra_fail_b", b1.fail_b, 32'hFFFF_FFFE);
        chk("sra_fail_got", b1.fail_got, 32'h0000_0001);
`endif
        @(posedge clk);
        #1 fault = 0;
        build_cum(0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_busy", b1.busy, 0);
        chk("midrst_done", b1.done, 0);
        chk("midrst_err", b1.err_count, 0);
        repeat (3) @(posedge clk);
        go(0);
        chk("rerun_err", b1.err_count, 0);
        chk("rerun_pass", b1.pass, 1);
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
